// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main_mem_burst backing store.
package main_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      TURN  = 2'd2,
      BURST = 2'd3
   } state_t;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned LINE_BYTES = 4;
   localparam int unsigned BEAT_W     = 2;

   // Aligns a byte address down to the start of its line.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:BEAT_W], BEAT_W'(0)};
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Single-port byte RAM: synchronous write, registered read with a resettable output.
module mem_byte_array #(
   parameter int unsigned AW = 10
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [7:0] mem [DEPTH];

   // Storage is deliberately left unreset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata <= 8'h00;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/main_mem_burst.sv
// Burst main memory behind cache_2wsa: 4-byte line fills and write-backs after LATENCY cycles.
// Optional sticky protocol checker enabled with `define PROTO_CHECK_EN.
module main_mem_burst
   import main_mem_pkg::*;
#(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned MEM_AW     = 10,
   parameter int unsigned LINE_BYTES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr_mem,
   input  logic        rd_mem,
   input  logic        wr_mem,
   input  logic [7:0]  data_wr,
   output logic [7:0]  data_rd,
   output logic        ready_mem,
   output logic        beat_valid,
   output logic [1:0]  beat_idx
`ifdef PROTO_CHECK_EN
   ,
   output logic        proto_err
`endif
);

   localparam int unsigned LAT_W = 4;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES - 1);

   state_t              state, state_n;
   logic [LAT_W-1:0]    lat_cnt, lat_cnt_n;
   logic [MEM_AW-1:0]   base, base_n;
   logic                is_wr, is_wr_n;
   logic                ready_n, beat_valid_n;
   logic [BEAT_W-1:0]   beat_idx_n;

   logic                req_c;
   logic                ram_we_c, ram_re_c;
   logic [BEAT_W-1:0]   ram_off_c;
   logic [MEM_AW-1:0]   ram_addr_c;

   assign req_c = rd_mem | wr_mem;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         base       <= '0;
         is_wr      <= 1'b0;
         ready_mem  <= 1'b1;
         beat_valid <= 1'b0;
         beat_idx   <= '0;
      end else begin
         state      <= state_n;
         lat_cnt    <= lat_cnt_n;
         base       <= base_n;
         is_wr      <= is_wr_n;
         ready_mem  <= ready_n;
         beat_valid <= beat_valid_n;
         beat_idx   <= beat_idx_n;
      end
   end

   // Next-state and registered-output decode; write wins when both requests are high.
   always_comb begin
      state_n      = state;
      lat_cnt_n    = lat_cnt;
      base_n       = base;
      is_wr_n      = is_wr;
      ready_n      = ready_mem;
      beat_valid_n = 1'b0;
      beat_idx_n   = beat_idx;
      case (state)
         IDLE: begin
            ready_n    = 1'b1;
            beat_idx_n = '0;
            if (req_c) begin
               base_n    = MEM_AW'(line_base(addr_mem));
               is_wr_n   = wr_mem;
               lat_cnt_n = LAT_W'(LATENCY - 1);
               ready_n   = 1'b0;
               state_n   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               ready_n = 1'b1;
               state_n = TURN;
            end else begin
               lat_cnt_n = lat_cnt - 1'b1;
            end
         end
         TURN: begin
            beat_valid_n = 1'b1;
            beat_idx_n   = '0;
            state_n      = BURST;
         end
         BURST: begin
            if (beat_idx == LAST_BEAT) begin
               beat_idx_n = '0;
               state_n    = IDLE;
            end else begin
               beat_valid_n = 1'b1;
               beat_idx_n   = beat_idx + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Reads run one beat ahead so the registered byte lands in its beat cycle.
   always_comb begin
      ram_we_c   = (state == BURST) && is_wr && !reset;
      ram_re_c   = !is_wr && ((state == TURN) ||
                              ((state == BURST) && (beat_idx != LAST_BEAT)));
      ram_off_c  = ((state == BURST) && !is_wr) ? beat_idx + 1'b1 : beat_idx;
      ram_addr_c = {base[MEM_AW-1:BEAT_W], ram_off_c};
   end

   mem_byte_array #(
      .AW (MEM_AW)
   ) u_array (
      .clock (clock),
      .reset (reset),
      .we    (ram_we_c),
      .re    (ram_re_c),
      .addr  (ram_addr_c),
      .wdata (data_wr),
      .rdata (data_rd)
   );

`ifdef PROTO_CHECK_EN
   logic rd_q, wr_q;
   logic viol_c;

   always_comb begin
      viol_c = 1'b0;
      if (state == IDLE) begin
         viol_c = (rd_mem && wr_mem) || (req_c && (addr_mem[1:0] != 2'b00));
      end else begin
         viol_c = (rd_mem && !rd_q) || (wr_mem && !wr_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         rd_q <= rd_mem;
         wr_q <= wr_mem;
         if (viol_c) begin
            proto_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_main_mem_burst.sv
// Scoreboard bench for main_mem_burst: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_main_mem_burst;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] addr_mem;
   logic        rd_mem, wr_mem;
   logic [7:0]  data_wr;
   logic        sel;

   logic        rd0, wr0, rd1, wr1;
   logic [7:0]  data_rd0, data_rd1;
   logic        ready0, ready1, bv0, bv1;
   logic [1:0]  bi0, bi1;

   logic [7:0]  data_rd_o;
   logic        ready_o, bv_o;
   logic [1:0]  bi_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  model [2][1024];
   logic [7:0]  exp_q [$];

   always #5 clock = ~clock;

   assign rd0 = sel ? 1'b0 : rd_mem;
   assign wr0 = sel ? 1'b0 : wr_mem;
   assign rd1 = sel ? rd_mem : 1'b0;
   assign wr1 = sel ? wr_mem : 1'b0;

   assign data_rd_o = sel ? data_rd1 : data_rd0;
   assign ready_o   = sel ? ready1   : ready0;
   assign bv_o      = sel ? bv1      : bv0;
   assign bi_o      = sel ? bi1      : bi0;

`ifdef PROTO_CHECK_EN
   logic perr0, perr1;
`endif

   main_mem_burst #(.LATENCY(4), .MEM_AW(10), .LINE_BYTES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .addr_mem   (addr_mem),
      .rd_mem     (rd0),
      .wr_mem     (wr0),
      .data_wr    (data_wr),
      .data_rd    (data_rd0),
      .ready_mem  (ready0),
      .beat_valid (bv0),
      .beat_idx   (bi0)
`ifdef PROTO_CHECK_EN
      ,
      .proto_err  (perr0)
`endif
   );

   main_mem_burst #(.LATENCY(1), .MEM_AW(10), .LINE_BYTES(4)) dut_l1 (
      .clock      (clock),
      .reset      (reset),
      .addr_mem   (addr_mem),
      .rd_mem     (rd1),
      .wr_mem     (wr1),
      .data_wr    (data_wr),
      .data_rd    (data_rd1),
      .ready_mem  (ready1),
      .beat_valid (bv1),
      .beat_idx   (bi1)
`ifdef PROTO_CHECK_EN
      ,
      .proto_err  (perr1)
`endif
   );

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One request on the selected instance; optionally reset during beat 2.
   task automatic run_burst(input logic s, input logic r, input logic w,
                            input logic [15:0] a, input logic [31:0] d,
                            input logic rst2);
      int         n;
      int         lat;
      logic       is_w;
      logic [9:0] mi;
      logic [7:0] e;
      logic [7:0] last;
      lat  = s ? 1 : 4;
      is_w = w;
      last = 8'h00;
      sel  = s;
      @(negedge clock);
      addr_mem = a;
      rd_mem   = r;
      wr_mem   = w;
      if (!is_w) begin
         for (int i = 0; i < 4; i++) begin
            mi = {a[9:2], 2'(i)};
            exp_q.push_back(model[s][mi]);
         end
      end
      @(negedge clock);
      rd_mem   = 1'b0;
      wr_mem   = 1'b0;
      addr_mem = 16'($urandom);
      n = 0;
      while (ready_o == 1'b0 && n < 20) begin
         n++;
         @(negedge clock);
      end
      check("latency", 16'(n), 16'(lat));
      check("turn_ready", 16'(ready_o), 16'h1);
      check("turn_bv", 16'(bv_o), 16'h0);
      data_wr = d[7:0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("beat_valid", 16'(bv_o), 16'h1);
         check("beat_idx", 16'(bi_o), 16'(i));
         check("burst_ready", 16'(ready_o), 16'h1);
         data_wr = d[8*i +: 8];
         if (!is_w) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("data_rd", 16'(data_rd_o), 16'(e));
            last = e;
         end
         if (rst2 && i == 2) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("rst_ready", 16'(ready_o), 16'h1);
            check("rst_bv", 16'(bv_o), 16'h0);
            return;
         end
         if (is_w) begin
            mi = {a[9:2], 2'(i)};
            model[s][mi] = d[8*i +: 8];
         end
      end
      @(negedge clock);
      check("idle_bv", 16'(bv_o), 16'h0);
      check("idle_ready", 16'(ready_o), 16'h1);
      if (!is_w) begin
         check("data_hold", 16'(data_rd_o), 16'(last));
      end
   endtask

   initial begin
      reset    = 1'b1;
      addr_mem = 16'h0000;
      rd_mem   = 1'b0;
      wr_mem   = 1'b0;
      data_wr  = 8'h00;
      sel      = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         check("rst_ready", 16'(ready_o), 16'h1);
         check("rst_bv", 16'(bv_o), 16'h0);
         check("rst_bi", 16'(bi_o), 16'h0);
         check("rst_data", 16'(data_rd_o), 16'h0);
      end
`ifdef PROTO_CHECK_EN
      check("rst_perr", 16'(perr0), 16'h0);
`endif
      // byte i of the data word is carried on beat i
      run_burst(1'b0, 1'b0, 1'b1, 16'h0010, 32'h88776655, 1'b0);
      run_burst(1'b0, 1'b0, 1'b1, 16'hC09B, 32'h8B8A8988, 1'b0);
      run_burst(1'b0, 1'b1, 1'b0, 16'hC09B, 32'h00000000, 1'b0);
      run_burst(1'b0, 1'b1, 1'b1, 16'h008C, 32'h44332211, 1'b0);
`ifdef PROTO_CHECK_EN
      check("perr_both", 16'(perr0), 16'h1);
`endif
      run_burst(1'b0, 1'b1, 1'b0, 16'h008C, 32'h00000000, 1'b0);
      run_burst(1'b0, 1'b0, 1'b1, 16'h0010, 32'hA3A2A1A0, 1'b1);
      run_burst(1'b0, 1'b1, 1'b0, 16'h0010, 32'h00000000, 1'b0);
      check("model_0x12", 16'(model[0][10'h012]), 16'h77);
      run_burst(1'b1, 1'b0, 1'b1, 16'h0404, 32'hEFBEADDE, 1'b0);
      run_burst(1'b1, 1'b1, 1'b0, 16'h0004, 32'h00000000, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/main_mem_burst.md
Name: main_mem_burst

Overview:
- Backing-store main memory for cache_2wsa: the stage directly downstream of the cache's memory port.
- Serves 4-byte line fills (rd_mem) and line write-backs (wr_mem) after a programmable access latency, signalled through ready_mem.
- Byte-wide data; 16-bit byte address; synthesizable register-array storage with parameterised depth.

Parameters:
- LATENCY, 4, cycles ready_mem is held low before a burst; legal range 1..15.
- MEM_AW, 10, log2 of storage bytes; the physical index is addr[MEM_AW-1:0], so higher addresses alias.
- LINE_BYTES, 4, bytes per burst; fixed at 4 in this revision.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- addr_mem  in  16  byte address from cache; line base = {addr_mem[15:2],2'b00}.
- rd_mem  in  1  line-fill request.
- wr_mem  in  1  line write-back request.
- data_wr  in  8  write-back byte for the current beat.
- data_rd  out  8  fill byte for the current beat.
- ready_mem  out  1  1 = idle or transferring; 0 = access in progress.
- beat_valid  out  1  a data beat occurs this cycle.
- beat_idx  out  2  byte offset of the current beat, 0..3.
- proto_err  out  1  sticky protocol error; present only with PROTO_CHECK_EN.

Behaviour:
- Reset values: ready_mem=1, beat_valid=0, beat_idx=0, data_rd=0, proto_err=0, state=IDLE. Storage contents are not reset.
- States: IDLE, WAIT, TURN, BURST.
- IDLE:
  - A request is sampled on a posedge with rd_mem|wr_mem=1.
  - Latch line base, latch direction, load lat_cnt=LATENCY-1, go to WAIT.
  - If rd_mem and wr_mem are both 1, the write wins: the cache evicts before it fills.
- WAIT:
  - ready_mem=0 for exactly LATENCY cycles, starting the cycle after the request is sampled.
  - lat_cnt decrements each cycle; at 0, go to TURN.
- TURN:
  - One cycle with ready_mem=1 and beat_valid=0. This gives the cache one clock to see ready before data.
  - Go to BURST with beat counter=0.
- BURST:
  - 4 consecutive cycles, beat_valid=1, beat_idx=0,1,2,3 in ascending order; no critical-word-first.
  - Read: data_rd = mem[base+beat_idx], registered so it is valid during the beat cycle.
  - Write: at the end of each beat cycle, mem[base+beat_idx] <= data_wr.
  - After beat 3, return to IDLE. A new request can be sampled on the first IDLE cycle.
- Address changes and requests during WAIT/TURN/BURST are ignored; address and direction are latched.
- Reset mid-operation: return to IDLE immediately with reset values. Write beats already committed stay in storage; the remaining beats are dropped.
- Outside BURST, data_rd holds its last value.
- Base index arithmetic is MEM_AW bits wide and wraps modulo 2^MEM_AW; the beat offset never carries into bit 2.

Optional Feature:
- Macro: PROTO_CHECK_EN.
- Defined:
  - proto_err sets and stays set until reset when any of these occurs:
    - rd_mem and wr_mem are both high in IDLE;
    - rd_mem or wr_mem rises while state is not IDLE;
    - addr_mem[1:0] is nonzero on an accepted request.
  - Behaviour is otherwise identical to the undefined build.
- Undefined: the proto_err port and its logic are absent, and violations are silently handled by the rules above.

Decomposition:
- Package main_mem_pkg holds:
  - state enum (IDLE/WAIT/TURN/BURST);
  - LINE_BYTES and beat-index width constants;
  - line_base() function that clears addr[1:0].
- One natural sub-module, mem_byte_array: a single-port byte RAM (sync write, registered read) of depth 2^MEM_AW.

Test Plan:
- Reset: after reset, ready_mem=1, beat_valid=0, beat_idx=0, data_rd=0.
- Write-back: wr_mem with addr 16'hC09B, data_wr per beat 88,89,8A,8B -> ready_mem low for 4 cycles, one TURN cycle, then beats 0..3; mem[0x098..0x09B] = 88,89,8A,8B.
- Fill: rd_mem with addr 16'hC09B after the write-back -> ready_mem low 4 cycles, TURN, then data_rd = 88,89,8A,8B with beat_idx 0..3; ready_mem high throughout the burst.
- Simultaneous request: rd_mem=wr_mem=1 at addr 16'h008C, data 11,22,33,44 -> a write burst occurs; a following read returns 11,22,33,44. With PROTO_CHECK_EN, proto_err=1.
- Reset mid-burst: assert reset during write beat 2 of a burst to 0x0010 carrying A0..A3 -> IDLE next cycle, ready_mem=1; a readback shows 0x10..0x11 = A0,A1 and 0x12..0x13 unchanged.
- Aliasing and latency: with MEM_AW=10 and LATENCY=1, write to 16'h0404, then read 16'h0004 -> the same 4 bytes are returned; ready_mem is low exactly 1 cycle.
